// File: rtl/fp_pkg.sv
// Shared widths, special-value constants and FSM state type for the FP adder add/normalize stage.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int AMANT_W = 24;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} addnorm_state_t;
endpackage

// File: rtl/fp_mant_addsub.sv
// Signed-magnitude add/subtract of two aligned mantissas; yields the 25-bit magnitude and its sign.
// Purely combinational: no latency and no flow control.
module fp_mant_addsub
    import fp_pkg::*;
(
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [AMANT_W-1:0] mant_a,
    input  logic [AMANT_W-1:0] mant_b,
    output logic [AMANT_W:0]   sum,
    output logic               sum_sign
);
    logic [AMANT_W:0] ext_a;
    logic [AMANT_W:0] ext_b;

    always_comb begin
        ext_a    = {1'b0, mant_a};
        ext_b    = {1'b0, mant_b};
        sum      = '0;
        sum_sign = sign_a;
        if (sign_a == sign_b) begin
            sum = ext_a + ext_b;
        end else if (mant_a >= mant_b) begin
            sum = ext_a - ext_b;
        end else begin
            sum      = ext_b - ext_a;
            sum_sign = sign_b;
        end
    end
endmodule

// File: rtl/fp_add_normalize.sv
// Add/normalize stage: one aligned pair in, packed single-precision result out, one left shift per NORM cycle.
// Latency 2 cycles plus one per shift; result is held in DONE until out_ready, and in_ready is high only when idle.
module fp_add_normalize
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signA,
    input  logic               signB,
    input  logic [EXP_W-1:0]   exponentIn,
    input  logic [AMANT_W-1:0] alignedMantissaA,
    input  logic [AMANT_W-1:0] alignedMantissaB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result
);
    addnorm_state_t     state;
    logic               sign_a, sign_b, sign_r;
    logic [EXP_W-1:0]   exp_q, exp_cnt;
    logic [AMANT_W-1:0] mant_a, mant_b, mant;

    logic [AMANT_W:0]   sum;
    logic               sum_sign;

    fp_mant_addsub u_addsub (
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .mant_a   (mant_a),
        .mant_b   (mant_b),
        .sum      (sum),
        .sum_sign (sum_sign)
    );

    assign in_ready = (state == IDLE);

    logic               add_go_norm;
    logic [31:0]        add_res;
    logic [EXP_W-1:0]   exp_inc;
    logic               a_special, b_special, a_nan, b_nan;

    // The special operand is the one whose hidden bit is clear.
    always_comb begin
        add_go_norm = 1'b0;
        add_res     = '0;
        exp_inc     = exp_q + 8'd1;
        a_special   = ~mant_a[AMANT_W-1];
        b_special   = ~mant_b[AMANT_W-1];
        a_nan       = a_special && (mant_a[MANT_W-1:0] != '0);
        b_nan       = b_special && (mant_b[MANT_W-1:0] != '0);
        if (exp_q == EXP_MAX) begin
            if (a_nan || b_nan || (a_special && b_special && (sign_a != sign_b)))
                add_res = QNAN;
            else
                add_res = {(a_special || !b_special) ? sign_a : sign_b, EXP_MAX, {MANT_W{1'b0}}};
        end else if (sum == '0) begin
            add_res = '0;
        end else if (sum[AMANT_W]) begin
            if (exp_inc == EXP_MAX)
                add_res = {sum_sign, EXP_MAX, {MANT_W{1'b0}}};
            else
                add_res = {sum_sign, exp_inc, sum[AMANT_W-1:1]};
        end else if (exp_q == '0) begin
            add_res = {sum_sign, EXP_W'(sum[AMANT_W-1]), sum[MANT_W-1:0]};
        end else if (!sum[AMANT_W-1] && (exp_q > 8'd1)) begin
            add_go_norm = 1'b1;
        end else begin
            add_res = {sum_sign, sum[AMANT_W-1] ? exp_q : {EXP_W{1'b0}}, sum[MANT_W-1:0]};
        end
    end

    logic [AMANT_W-1:0] norm_mant;
    logic [EXP_W-1:0]   norm_exp;
    logic               norm_done;
    logic [31:0]        norm_res;

    // Exit on the shifted value; reaching exponent 1 without a hidden bit means subnormal.
    always_comb begin
        norm_mant = {mant[AMANT_W-2:0], 1'b0};
        norm_exp  = exp_cnt - 8'd1;
        norm_done = norm_mant[AMANT_W-1] || (norm_exp == 8'd1);
        norm_res  = {sign_r, norm_mant[AMANT_W-1] ? norm_exp : {EXP_W{1'b0}}, norm_mant[MANT_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            sign_r    <= 1'b0;
            exp_q     <= '0;
            exp_cnt   <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            mant      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a <= signA;
                        sign_b <= signB;
                        exp_q  <= exponentIn;
                        mant_a <= alignedMantissaA;
                        mant_b <= alignedMantissaB;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (add_go_norm) begin
                        mant    <= sum[AMANT_W-1:0];
                        exp_cnt <= exp_q;
                        sign_r  <= sum_sign;
                        state   <= NORM;
                    end else begin
                        result    <= add_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                NORM: begin
                    mant    <= norm_mant;
                    exp_cnt <= norm_exp;
                    if (norm_done) begin
                        result    <= norm_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed-vector bench for fp_add_normalize with hand-computed results and latencies.
module tb_fp_add_normalize;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        signA, signB;
    logic [7:0]  exponentIn;
    logic [23:0] alignedMantissaA, alignedMantissaB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    fp_add_normalize dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .signA            (signA),
        .signB            (signB),
        .exponentIn       (exponentIn),
        .alignedMantissaA (alignedMantissaA),
        .alignedMantissaB (alignedMantissaB),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result)
    );

    always #5 clk = ~clk;

    // Drives one operation from IDLE; lat counts negedges after the accept cycle until out_valid.
    task automatic do_op(input logic sa, input logic sb, input logic [7:0] e,
                         input logic [23:0] ma, input logic [23:0] mb, output int lat);
        @(negedge clk);
        signA = sa; signB = sb; exponentIn = e;
        alignedMantissaA = ma; alignedMantissaB = mb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_same_sign();
        int lat;
        do_op(1'b0, 1'b0, 8'h7F, 24'h800000, 24'h800000, lat);
        checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL one_plus_one: got %h expected 40000000", result); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL one_plus_one_lat: got %0d expected 2", lat); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
        release_out();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_return: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_norm();
        int lat;
        do_op(1'b0, 1'b1, 8'h7F, 24'h800000, 24'h600000, lat);
        checks++; if (result !== 32'h3E800000) begin errors++; $display("FAIL one_minus_075: got %h expected 3E800000", result); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL one_minus_075_lat: got %0d expected 4", lat); end
        release_out();
        do_op(1'b1, 1'b0, 8'h7F, 24'h600000, 24'h800000, lat);
        checks++; if (result !== 32'h3E800000) begin errors++; $display("FAIL b_larger_sign: got %h expected 3E800000", result); end
        release_out();
    endtask

    task automatic test_cancel_overflow();
        int lat;
        do_op(1'b0, 1'b1, 8'h85, 24'hC00000, 24'hC00000, lat);
        checks++; if (result !== 32'h00000000) begin errors++; $display("FAIL cancel: got %h expected 00000000", result); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL cancel_lat: got %0d expected 2", lat); end
        release_out();
        do_op(1'b0, 1'b0, 8'hFE, 24'h800000, 24'h800000, lat);
        checks++; if (result !== 32'h7F800000) begin errors++; $display("FAIL overflow: got %h expected 7F800000", result); end
        release_out();
    endtask

    task automatic test_special();
        int lat;
        do_op(1'b0, 1'b1, 8'hFF, 24'h000000, 24'h000000, lat);
        checks++; if (result !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf: got %h expected 7FC00000", result); end
        release_out();
        do_op(1'b0, 1'b0, 8'hFF, 24'h800000, 24'h000001, lat);
        checks++; if (result !== 32'h7FC00000) begin errors++; $display("FAIL nan_b: got %h expected 7FC00000", result); end
        release_out();
        do_op(1'b0, 1'b1, 8'hFF, 24'h800000, 24'h000000, lat);
        checks++; if (result !== 32'hFF800000) begin errors++; $display("FAIL inf_b_sign: got %h expected FF800000", result); end
        release_out();
    endtask

    task automatic test_subnormal();
        int lat;
        do_op(1'b0, 1'b0, 8'h00, 24'h400000, 24'h400000, lat);
        checks++; if (result !== 32'h00800000) begin errors++; $display("FAIL subnorm_carry: got %h expected 00800000", result); end
        release_out();
        do_op(1'b0, 1'b1, 8'h02, 24'h800000, 24'h600000, lat);
        checks++; if (result !== 32'h00400000) begin errors++; $display("FAIL norm_to_subnorm: got %h expected 00400000", result); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL norm_to_subnorm_lat: got %0d expected 3", lat); end
        release_out();
    endtask

    task automatic test_worst_case();
        int lat;
        do_op(1'b0, 1'b1, 8'h7F, 24'h800000, 24'h7FFFFF, lat);
        checks++; if (result !== 32'h34000000) begin errors++; $display("FAIL worst_case: got %h expected 34000000", result); end
        checks++; if (lat !== 25) begin errors++; $display("FAIL worst_case_lat: got %0d expected 25", lat); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(1'b1, 1'b1, 8'h7F, 24'h800000, 24'h800000, lat);
        // A new pair offered while busy must be ignored.
        signA = 1'b0; exponentIn = 8'h10; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (result !== 32'hC0000000) begin errors++; $display("FAIL hold_result[%0d]: got %h expected C0000000", i, result); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_hs[%0d]: got rdy=%b vld=%b expected rdy=0 vld=1", i, in_ready, out_valid); end
        end
        in_valid = 1'b0;
        release_out();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        signA = 1'b0; signB = 1'b1; exponentIn = 8'h7F;
        alignedMantissaA = 24'h800000; alignedMantissaB = 24'h7FFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL midrst_no_result: got vld=%b res=%h expected vld=0 res=00000000", out_valid, result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(1'b0, 1'b0, 8'h80, 24'h800000, 24'hC00000, lat);
        checks++; if (result !== 32'h40A00000) begin errors++; $display("FAIL b2b_first: got %h expected 40A00000", result); end
        release_out();
        do_op(1'b1, 1'b0, 8'h7E, 24'hA00000, 24'h800000, lat);
        checks++; if (result !== 32'hBE000000) begin errors++; $display("FAIL b2b_second: got %h expected BE000000", result); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_lat: got %0d expected 4", lat); end
        release_out();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        signA = 1'b0; signB = 1'b0; exponentIn = '0;
        alignedMantissaA = '0; alignedMantissaB = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_same_sign();
        test_norm();
        test_cancel_overflow();
        test_special();
        test_subnormal();
        test_worst_case();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_add_normalize.md
# fp_add_normalize

Add/normalize stage of the single-precision FP adder, directly downstream of the alignment stage. It accepts one aligned operand pair (shared exponent plus two 24-bit aligned mantissas with hidden bit) over a valid/ready handshake. It performs signed-magnitude add/subtract and normalizes the result iteratively, one left shift per cycle. It then presents a packed IEEE-754 single-precision result, held until the consumer accepts it.

## Interface
- No parameters; widths are fixed by `fp_pkg` (EXP_W=8, MANT_W=23, AMANT_W=24).
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the aligned operand pair on the inputs is valid.
- `in_ready` output 1: the stage can accept; high only in IDLE.
- `signA`, `signB` input 1 each: operand signs.
- `exponentIn` input 8: shared exponent produced by alignment.
- `alignedMantissaA`, `alignedMantissaB` input 24 each: bit 23 is the hidden bit.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts `result`.
- `result` output 32: packed {sign, exponent[7:0], mantissa[22:0]}.

## Operation
- FSM states and transitions:
  - IDLE → ADD on `in_valid & in_ready`. On that edge, all inputs are captured into registers.
  - ADD → DONE when no normalization is needed; otherwise ADD → NORM.
  - NORM → DONE once normalization ends.
  - DONE → IDLE on `out_ready`.
- ADD (one cycle, 25-bit arithmetic):
  - Same signs: sum = mA + mB; sign = signA.
  - Different signs, mA ≥ mB: sum = mA − mB; sign = signA.
  - Different signs, mB > mA: sum = mB − mA; sign = signB.
  - sum == 0: result = 32'h00000000 (+0), go to DONE.
  - sum[24] = 1: mantissa = sum[24:1] (truncate, no rounding), exp + 1.
    - If exp + 1 == 8'hFF: result = {sign, 8'hFF, 0}.
    - Either way, go to DONE.
  - exponentIn == 0 (both operands subnormal or zero): exp = sum[23] ? 1 : 0, mantissa = sum[22:0], go to DONE.
  - Otherwise go to NORM if sum[23] == 0 and exp > 1, else DONE.
- NORM: each cycle mant <<= 1, exp −= 1. Leave when mant[23] == 1 or exp == 1.
  - If exp == 1 and mant[23] == 0 on exit, the emitted exponent is 0 (subnormal).
  - At most 23 NORM cycles.
- Special inputs (exponentIn == 8'hFF) are resolved in ADD, then go to DONE. An operand with bit 23 == 0 is the special one.
  - NaN: the special operand has [22:0] ≠ 0 → result = 32'h7FC00000.
  - Inf − Inf: both operands special, [22:0] == 0, signs differ → result = 32'h7FC00000.
  - Otherwise: result = {sign of the special operand (A preferred), 8'hFF, 23'h0}.

## Timing
- Reset values: state = IDLE, `out_valid` = 0, `result` = 32'h0, `in_ready` = 1.
- Latency: an accept on edge k with no shifts gives `out_valid` high in cycle k+2. Each NORM shift adds one cycle (worst case k+25).
- `result` is registered and stable while `out_valid` is high. It may change only after the `out_valid & out_ready` edge.
- `in_ready` drops the cycle after acceptance and returns the cycle after the result is accepted. No overlap between operations; throughput is at most one operation per 3 cycles.
- Inputs are ignored outside IDLE. `in_valid` without `in_ready` has no effect.
- `out_ready` high outside DONE has no effect.
- Asserting `rst_n` low mid-operation abandons the operation immediately; no partial result is emitted.

## Structure
- `fp_pkg` holds:
  - Width constants (EXP_W, MANT_W, AMANT_W).
  - Constants `EXP_MAX` = 8'hFF and `QNAN` = 32'h7FC00000.
  - The state enum `addnorm_state_t` {IDLE, ADD, NORM, DONE}.
- One combinational sub-module, `fp_mant_addsub`:
  - Inputs: signs and the two 24-bit mantissas.
  - Outputs: the 25-bit magnitude and the result sign.
- The top module owns the FSM, the shift register and the exponent counter.

## Test plan
- 1.0 + 1.0 (exponentIn = 7F, mA = mB = 800000, both signs 0) → result 40000000, `out_valid` 2 cycles after accept.
- 1.0 − 0.75 (exponentIn = 7F, mA = 800000, mB = 600000, signB = 1) → 2 NORM cycles, result 3E800000, `out_valid` at accept + 4.
- Exact cancellation (exponentIn = 85, mA = mB = C00000, signs differ) → result 00000000.
- Overflow (exponentIn = FE, mA = mB = 800000, both signs 0) → result 7F800000.
- Inf − Inf (exponentIn = FF, mA = mB = 000000, signA = 0, signB = 1) → result 7FC00000.
- Backpressure and reset:
  - Hold `out_ready` low 5 cycles in DONE → `result` stable, `in_ready` = 0 throughout.
  - Pulse `rst_n` low during NORM → `out_valid` = 0 and `in_ready` = 1 immediately.
